// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: masked DRP read-modify-write of MMCM registers while mmcm_rst is held, then waits for lock.
// Define MMCM_DRP_READBACK_EN to re-read and verify every written register.
module mmcm_drp_reconfig #(
  parameter int RST_HOLD = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic [15:0] req_mask,
  input  logic        req_last,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] do_in,
  input  logic        drdy,
  output logic        mmcm_rst,
  input  logic        locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ?
    ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD) :
    ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
`ifdef MMCM_DRP_READBACK_EN
    S_VFY, S_VFY_WAIT,
`endif
    S_NEXT, S_RELEASE, S_LOCK_WAIT, S_DONE
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [6:0] addr_q;
  logic [15:0] data_q, mask_q, do_cap, wr_val;
  logic last_q, take, fail, tmo;
  logic [1:0] code_n;
  assign wr_val = (do_cap & mask_q) | (data_q & ~mask_q);
  assign tmo = cnt == CW'(DRDY_TIMEOUT - 1);
  assign daddr = den ? addr_q : '0;
  assign di = dwe ? wr_val : '0;
  assign mmcm_rst = !(state inside {S_IDLE, S_RELEASE, S_LOCK_WAIT, S_DONE});
  assign busy = !(state inside {S_IDLE, S_DONE});
  assign done = state == S_DONE;
  always_comb begin
    state_n = state;
    take = 1'b0;
    fail = 1'b0;
    code_n = 2'b01;
    req_ready = 1'b0;
    den = 1'b0;
    dwe = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = resetn;
        take = req_valid & resetn;
        state_n = take ? S_RST_HOLD : S_IDLE;
      end
      S_RST_HOLD: state_n = (cnt == CW'(RST_HOLD - 1)) ? S_RD : S_RST_HOLD;
      S_RD: begin
        den = 1'b1;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        fail = !drdy && tmo;
        state_n = drdy ? S_WR : fail ? S_IDLE : S_RD_WAIT;
      end
      S_WR: begin
        den = 1'b1;
        dwe = 1'b1;
        state_n = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        fail = !drdy && tmo;
`ifdef MMCM_DRP_READBACK_EN
        state_n = drdy ? S_VFY : fail ? S_IDLE : S_WR_WAIT;
`else
        state_n = drdy ? S_NEXT : fail ? S_IDLE : S_WR_WAIT;
`endif
      end
`ifdef MMCM_DRP_READBACK_EN
      S_VFY: begin
        den = 1'b1;
        state_n = S_VFY_WAIT;
      end
      S_VFY_WAIT: begin
        fail = drdy ? (do_in != wr_val) : tmo;
        code_n = drdy ? 2'b11 : 2'b01;
        state_n = fail ? S_IDLE : drdy ? S_NEXT : S_VFY_WAIT;
      end
`endif
      S_NEXT: begin
        req_ready = !last_q;
        take = req_valid & !last_q;
        state_n = last_q ? S_RELEASE : take ? S_RD : S_NEXT;
      end
      S_RELEASE: state_n = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        fail = !locked && cnt == CW'(LOCK_TIMEOUT - 1);
        code_n = 2'b10;
        state_n = locked ? S_DONE : fail ? S_IDLE : S_LOCK_WAIT;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // cnt restarts on every state change, so each wait measures from its own entry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      do_cap <= '0;
      err <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      if (take) begin
        addr_q <= req_addr;
        data_q <= req_data;
        mask_q <= req_mask;
        last_q <= req_last;
      end
      if (state == S_RD_WAIT && drdy) do_cap <= do_in;
      if (fail) begin
        err <= 1'b1;
        err_code <= code_n;
      end else if (take) begin
        err <= 1'b0;
        err_code <= 2'b00;
      end
    end
  end
endmodule

// File: doc/mmcm_drp_reconfig.md
MMCM_DRP_RECONFIG -- requirements
Module: mmcm_drp_reconfig

Interface
REQ-001 Parameter RST_HOLD, default 4: cycles mmcm_rst is held asserted before the first DRP access.
REQ-002 Parameter DRDY_TIMEOUT, default 64: maximum cycles spent waiting for drdy after den.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum cycles spent waiting for locked after mmcm_rst is released.
REQ-004 Port clk, input, 1: single clock; also drives the MMCM DCLK.
REQ-005 Port resetn, input, 1: synchronous, active-low reset.
REQ-006 Ports req_valid in 1, req_ready out 1, req_addr in 7, req_data in 16, req_mask in 16, req_last in 1: write-request stream; req_mask bit=1 preserves the current register bit.
REQ-007 Ports daddr out 7, di out 16, den out 1, dwe out 1, do_in in 16, drdy in 1: DRP initiator side.
REQ-008 Ports mmcm_rst out 1 and locked in 1: MMCM reset drive and lock status.
REQ-009 Ports busy out 1, done out 1 (one-cycle pulse), err out 1, err_code out 2: status; err_code 01=drdy timeout, 10=lock timeout, 11=readback mismatch.

Function
REQ-010 FSM states SHALL be IDLE, RST_HOLD, RD, RD_WAIT, WR, WR_WAIT, VFY, VFY_WAIT, NEXT, RELEASE, LOCK_WAIT and DONE.
REQ-011 In IDLE, req_ready SHALL be 1, and a req_valid&req_ready handshake SHALL latch addr/data/mask/last, set mmcm_rst=1 and busy=1, and go to RST_HOLD.
REQ-012 RST_HOLD SHALL count RST_HOLD cycles and then go to RD; mmcm_rst SHALL stay 1 from the entry to RST_HOLD until RELEASE.
REQ-013 RD SHALL drive den=1, dwe=0, daddr=latched address for exactly one cycle, then go to RD_WAIT.
REQ-014 RD_WAIT SHALL wait for drdy and capture do_in on the drdy cycle.
REQ-015 WR SHALL drive den=1, dwe=1 and di=(do_cap & mask) | (data & ~mask) for exactly one cycle, then go to WR_WAIT.
REQ-016 WR_WAIT SHALL exit on drdy to VFY when DRP_READBACK_EN is defined, and to NEXT otherwise.
REQ-017 den SHALL never be asserted while a previous access is awaiting drdy, and outside RD/WR/VFY den and dwe SHALL be 0.
REQ-018 NEXT SHALL go to RELEASE if the latched last=1; otherwise it SHALL assert req_ready, latch the next handshake, and go to RD, holding indefinitely while req_valid=0.
REQ-019 req_ready SHALL be 0 in every state except IDLE and NEXT.
REQ-020 RELEASE SHALL deassert mmcm_rst and go to LOCK_WAIT.
REQ-021 LOCK_WAIT SHALL go to DONE on locked=1.
REQ-022 DONE SHALL pulse done=1 for one cycle, clear busy, and return to IDLE.
REQ-023 Each drdy wait state SHALL count from 0, and reaching DRDY_TIMEOUT SHALL set err=1 and err_code=01.
REQ-024 In LOCK_WAIT, reaching LOCK_TIMEOUT SHALL set err=1 and err_code=10.
REQ-025 Any error SHALL deassert mmcm_rst and go to IDLE without a done pulse.
REQ-026 err SHALL remain set until the next accepted request, which clears err and err_code.
REQ-027 A drdy arriving in any state other than RD_WAIT, WR_WAIT or VFY_WAIT SHALL be ignored.
REQ-028 Wait counters SHALL saturate and never wrap.

Reset
REQ-029 While resetn=0 at a clk edge, state SHALL become IDLE and counters SHALL clear.
REQ-030 While resetn=0 at a clk edge, outputs SHALL be: mmcm_rst=0, den=0, dwe=0, daddr=0, di=0, busy=0, done=0, err=0, err_code=00 and req_ready=0.
REQ-031 req_ready SHALL become 1 on the first cycle after resetn=1.
REQ-032 Reset asserted mid-sequence SHALL abort immediately, with no further den.

Configuration
REQ-033 Macro MMCM_DRP_READBACK_EN SHALL control readback verification.
REQ-034 When MMCM_DRP_READBACK_EN is defined, VFY SHALL re-read the address (den=1, dwe=0), and VFY_WAIT SHALL compare do_in with the written value: a mismatch SHALL set err_code=11 and take the error path, and a match SHALL go to NEXT.
REQ-035 When MMCM_DRP_READBACK_EN is not defined, the VFY and VFY_WAIT states SHALL be absent, and err_code=11 SHALL never occur.

Verification
REQ-036 Single request addr=0x08, data=0x1041, mask=0xF000, DRP model returns 0xA5A5, last=1 -> write di=0xA041; mmcm_rst high for at least 4 cycles; done pulse after locked rises.
REQ-037 Three requests with last on the third and a 5-cycle req_valid gap before the second -> exactly 3 writes in order, mmcm_rst continuously high, and no den during the gap.
REQ-038 Responder never asserts drdy -> err=1, err_code=01 exactly 64 cycles after the read den; mmcm_rst=0; no done pulse.
REQ-039 locked held at 0 with LOCK_TIMEOUT=100 -> err_code=10 after 100 cycles, then a new request clears err.
REQ-040 With MMCM_DRP_READBACK_EN defined, responder corrupts the readback to 0x0000 after writing 0xA041 -> err_code=11.
REQ-041 resetn driven low during WR_WAIT -> den=0, mmcm_rst=0 and busy=0 on the next edge; a subsequent request completes normally.
